idct4_transpose_buf: RTL and testbench
======================================

// Module: idct4_transpose_buf
// PURPOSE
//  Inter-pass buffer of the 4x4 inverse-transform datapath, directly upstream of the second-pass column engine.
//  Accepts first-pass row results, one 4-element row per cycle.
//  Applies first-pass rounding: (x+ADD)>>>SHIFT, then saturates to CLIP_W bits.
//  Stores rows in a ping-pong pair of 4x4 banks and emits the transposed columns, one column per cycle.
//  Column element k drives second-pass input d_in_k.
// PARAMETERS
//  DW      25   data width of all sample ports, signed two's complement
//  SHIFT   7    first-pass right shift, arithmetic
//  ADD     64   first-pass rounding offset (1<<(SHIFT-1))
//  CLIP_W  16   saturation width of stored samples
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-low reset
//  in_valid  in   1      d_in_1..4 hold a valid row
//  in_ready  out  1      buffer can accept a row this cycle
//  d_in_1    in   DW     row element, column 0 (d_in_2..d_in_4: columns 1..3)
//  out_valid out  1      d_out_1..4 hold a valid column
//  out_ready in   1      downstream accepts column this cycle
//  d_out_1   out  DW     column element, row 0 (d_out_2..d_out_4: rows 1..3), sign-extended from CLIP_W
// BEHAVIOUR
//  - Reset (reset==0 at rising edge):
//    - wr_bank, wr_row, rd_bank, rd_col and full[1:0] cleared; all bank storage cleared to 0.
//    - Therefore out_valid=0, in_ready=1, d_out_1..4=0.
//    - Reset mid-block discards all partial and full blocks.
//  - Arithmetic, applied on write:
//    - t = (x + ADD) >>> SHIFT, computed in DW+1 bits (no overflow at x=2^(DW-1)-1).
//    - Saturate t to [-2^(CLIP_W-1), 2^(CLIP_W-1)-1]; store CLIP_W bits.
//  - Write side:
//    - in_ready = !full[wr_bank].
//    - On in_valid&&in_ready: bank[wr_bank][wr_row][c] <= sat(d_in_{c+1}); wr_row++.
//    - When wr_row==3: set full[wr_bank], wr_row<=0, toggle wr_bank.
//  - Read side:
//    - out_valid = full[rd_bank]; d_out_k = bank[rd_bank][k-1][rd_col].
//    - Outputs are driven combinationally from registers and held stable while out_valid && !out_ready.
//    - On out_valid&&out_ready: rd_col++. When rd_col==3: clear full[rd_bank], rd_col<=0, toggle rd_bank.
//  - Latency: 4th row accepted at edge N -> first column valid in cycle after N.
//  - Throughput: sustained 1 row in / 1 column out per cycle with out_ready=1; in_ready never drops.
//  - Simultaneous events:
//    - Fill of one bank and drain of the other in the same cycle are both honoured.
//    - Set and clear of the same bank in one cycle cannot occur, because writes require !full.
//  - Both banks full: in_ready=0 until the current read bank fully drains; the row on d_in is held, not lost.
//  - in_valid/out_ready are ignored in cycles where in_ready/out_valid are low.
// STRUCTURE
//  - Shared package idct_pkg:
//    - DW, per-pass SHIFT/ADD constants (pass1: 7/64, pass2: 12/2048);
//    - CLIP_W and its min/max constants;
//    - typedef for a signed DW sample.
//  - Sub-module idct_round_clip: combinational round/shift/saturate, instantiated 4x on the write path.
//  - This module: control counters, full flags, 2x4x4xCLIP_W register banks, read mux.
// TESTING
//  1. Reset held 2 cycles -> in_ready=1, out_valid=0, d_out_1..4=0.
//     Release, then 3 rows -> out_valid stays 0.
//  2. Rows x[r][c]=(4r+c)*128, out_ready=1:
//     - out_valid rises the cycle after row 3;
//     - columns out are (0,4,8,12),(1,5,9,13),(2,6,10,14),(3,7,11,15) on consecutive cycles.
//  3. Rounding/saturation on d_in_1:
//     - 63->0, 64->1, -64->0, -65->-1;
//     - 16777215->32767 and -16777216->-32768 (sign-extended on d_out).
//  4. Back-to-back: 8 rows on 8 consecutive cycles with out_ready=1:
//     - in_ready stays 1;
//     - 8 columns emerge on consecutive cycles in block order.
//  5. Backpressure: out_ready=0, offer 9 rows:
//     - in_ready drops after row 8; row 9 stalls with d_out held;
//     - 4 accepted columns later in_ready=1 and row 9 is written.
//  6. Reset after 6 rows with out_valid=1 -> next cycle out_valid=0, in_ready=1.
//     - A fresh block then transposes correctly.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants and sample types for the 4x4 inverse-transform datapath.
package idct_pkg;
    localparam int DW       = 25;
    localparam int N        = 4;

    // Pass-1 feeds the transpose buffer; pass-2 constants are used by the column engine.
    localparam int P1_SHIFT = 7;
    localparam int P1_ADD   = 1 << (P1_SHIFT - 1);
    localparam int P2_SHIFT = 12;
    localparam int P2_ADD   = 1 << (P2_SHIFT - 1);

    localparam int CLIP_W   = 16;
    localparam int CLIP_MAX = (1 << (CLIP_W - 1)) - 1;
    localparam int CLIP_MIN = -(1 << (CLIP_W - 1));

    typedef logic signed [DW-1:0]     sample_t;
    typedef logic signed [CLIP_W-1:0] clip_t;

    function automatic sample_t sext_clip(input clip_t v);
        return {{(DW - CLIP_W){v[CLIP_W-1]}}, v};
    endfunction
endpackage

// File: rtl/idct4_transpose_buf_if.sv
// Row-in / column-out handshake bundle of the inter-pass transpose buffer.
interface idct4_transpose_buf_if;
    import idct_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t d_in_1;
    sample_t d_in_2;
    sample_t d_in_3;
    sample_t d_in_4;

    logic    out_valid;
    logic    out_ready;
    sample_t d_out_1;
    sample_t d_out_2;
    sample_t d_out_3;
    sample_t d_out_4;

    modport master (
        output in_valid, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
        input  in_ready, out_valid, d_out_1, d_out_2, d_out_3, d_out_4
    );

    modport slave (
        input  in_valid, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
        output in_ready, out_valid, d_out_1, d_out_2, d_out_3, d_out_4
    );
endinterface

// File: rtl/idct_round_clip.sv
// Combinational round, arithmetic shift and saturation of one sample to CLIP_W bits.
module idct_round_clip
    import idct_pkg::*;
#(
    parameter int SHIFT = P1_SHIFT,
    parameter int ADD   = P1_ADD
) (
    input  sample_t i_x,
    output clip_t   o_y
);
    localparam logic signed [DW:0] L_ADD = (DW + 1)'(ADD);
    localparam logic signed [DW:0] L_MAX = (DW + 1)'(CLIP_MAX);
    localparam logic signed [DW:0] L_MIN = (DW + 1)'(CLIP_MIN);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    logic signed [DW:0] w_sum;
    logic signed [DW:0] w_shr;

    assign w_sum = {i_x[DW-1], i_x} + L_ADD;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        if (w_shr > L_MAX) begin
            o_y = clip_t'(CLIP_MAX);
        end else if (w_shr < L_MIN) begin
            o_y = clip_t'(CLIP_MIN);
        end else begin
            o_y = w_shr[CLIP_W-1:0];
        end
    end
endmodule

// File: rtl/idct4_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: rounded rows in, columns out, one per cycle each.
module idct4_transpose_buf
    import idct_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    idct4_transpose_buf_if.slave  bus
);
    clip_t       r_bank [2][N][N];
    logic        r_wr_bank;
    logic [1:0]  r_wr_row;
    logic        r_rd_bank;
    logic [1:0]  r_rd_col;
    logic [1:0]  r_full;

    sample_t     w_din  [N];
    clip_t       w_clip [N];
    sample_t     w_dout [N];
    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [1:0]  w_full_next;

    assign w_din[0] = bus.d_in_1;
    assign w_din[1] = bus.d_in_2;
    assign w_din[2] = bus.d_in_3;
    assign w_din[3] = bus.d_in_4;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            idct_round_clip #(
                .SHIFT (P1_SHIFT),
                .ADD   (P1_ADD)
            ) u_round_clip (
                .i_x (w_din[gi]),
                .o_y (w_clip[gi])
            );

            // Lane gi of the output column is row gi of the selected column.
            assign w_dout[gi] = sext_clip(r_bank[r_rd_bank][gi][r_rd_col]);
        end
    endgenerate

    assign bus.d_out_1   = w_dout[0];
    assign bus.d_out_2   = w_dout[1];
    assign bus.d_out_3   = w_dout[2];
    assign bus.d_out_4   = w_dout[3];

    assign bus.in_ready  = !r_full[r_wr_bank];
    assign bus.out_valid = r_full[r_rd_bank];
    assign w_wr_fire     = bus.in_valid && bus.in_ready;
    assign w_rd_fire     = bus.out_valid && bus.out_ready;

    // A bank is only written while empty, so set and clear never target the same bank.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_fire && (r_wr_row == 2'd3)) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire && (r_rd_col == 2'd3)) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= 2'd0;
            r_rd_bank <= 1'b0;
            r_rd_col  <= 2'd0;
            r_full    <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        r_bank[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            r_full <= w_full_next;

            if (w_wr_fire) begin
                for (int c = 0; c < N; c++) begin
                    r_bank[r_wr_bank][r_wr_row][c] <= w_clip[c];
                end
                r_wr_row <= r_wr_row + 2'd1;
                if (r_wr_row == 2'd3) begin
                    r_wr_bank <= !r_wr_bank;
                end
            end

            if (w_rd_fire) begin
                r_rd_col <= r_rd_col + 2'd1;
                if (r_rd_col == 2'd3) begin
                    r_rd_bank <= !r_rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_idct4_transpose_buf.sv
// Scoreboard bench for idct4_transpose_buf: model queues expected columns, monitor pops on each transfer.
module tb_idct4_transpose_buf;
    import idct_pkg::*;

    typedef struct {
        int e[4];
    } col_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    idct4_transpose_buf_if bus ();

    idct4_transpose_buf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cols  = 0;
    col_t exp_q[$];
    int   blk[4][4];
    int   blk_rows = 0;
    col_t mon_col;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic signed [63:0] dout(input int k);
        case (k)
            0:       return $signed(bus.d_out_1);
            1:       return $signed(bus.d_out_2);
            2:       return $signed(bus.d_out_3);
            default: return $signed(bus.d_out_4);
        endcase
    endfunction

    // Reference rounding: floor((x + ADD) / 2^SHIFT) then clamp to the signed CLIP_W range.
    function automatic int ref_round(input int x);
        longint s;
        longint d;
        longint q;
        s = longint'(x) + P1_ADD;
        d = longint'(1) << P1_SHIFT;
        q = (s >= 0) ? s / d : -((-s + d - 1) / d);
        if (q > CLIP_MAX) q = CLIP_MAX;
        if (q < CLIP_MIN) q = CLIP_MIN;
        return int'(q);
    endfunction

    function automatic void model_row(input int a, input int b, input int c, input int d);
        int v[4];
        col_t col;
        v = '{a, b, c, d};
        for (int j = 0; j < 4; j++) blk[blk_rows][j] = ref_round(v[j]);
        blk_rows++;
        if (blk_rows == 4) begin
            for (int j = 0; j < 4; j++) begin
                for (int r = 0; r < 4; r++) col.e[r] = blk[r][j];
                exp_q.push_back(col);
            end
            blk_rows = 0;
        end
    endfunction

    function automatic int rnd_sample();
        logic [24:0] t;
        t = 25'($urandom);
        case ($urandom_range(0, 2))
            0:       return int'($signed(t));
            1:       return int'($urandom_range(0, 1 << 20)) - (1 << 19);
            default: return ($urandom_range(0, 1) != 0) ? (16777215 - int'($urandom_range(0, 300000)))
                                                          : (-16777216 + int'($urandom_range(0, 300000)));
        endcase
    endfunction

    task automatic drive_row(input int a, input int b, input int c, input int d);
        bus.d_in_1 = sample_t'(a);
        bus.d_in_2 = sample_t'(b);
        bus.d_in_3 = sample_t'(c);
        bus.d_in_4 = sample_t'(d);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the row.
    task automatic send_row(input int a, input int b, input int c, input int d, output int waits);
        drive_row(a, b, c, d);
        bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (bus.in_ready) model_row(a, b, c, d);
        else check("row_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand_row(output int waits);
        send_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), waits);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        check({name, "_idle"}, bus.out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_column", 1, 0);
            end else begin
                mon_col = exp_q.pop_front();
                $display("[TB] col %0d: %0d %0d %0d %0d", n_cols,
                         dout(0), dout(1), dout(2), dout(3));
                for (int k = 0; k < 4; k++)
                    check($sformatf("col%0d_e%0d", n_cols, k), dout(k), mon_col.e[k]);
            end
            n_cols++;
        end
    end

    initial begin
        int w;
        int stalls;
        int c0;
        int v1[4];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_row(0, 0, 0, 0);

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_dout%0d", k), dout(k), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp block: three rows keep out_valid low, the fourth raises it next cycle
        bus.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send_row((4*r) * 128, (4*r + 1) * 128, (4*r + 2) * 128, (4*r + 3) * 128, w);
            check($sformatf("ramp_row%0d_no_valid", r), bus.out_valid, 0);
        end
        send_row(12 * 128, 13 * 128, 14 * 128, 15 * 128, w);
        bus.in_valid = 1'b0;
        check("ramp_valid_after_row3", bus.out_valid, 1);
        for (int k = 0; k < 4; k++) check($sformatf("ramp_col0_e%0d", k), dout(k), 4 * k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ramp_consec_valid%0d", i), bus.out_valid, 1);
            check($sformatf("ramp_col%0d_row0", i), dout(0), i);
        end
        @(negedge clk);
        check("ramp_valid_drop", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Rounding boundaries, observed on a held column
        bus.out_ready = 1'b0;
        v1 = '{63, 64, -64, -65};
        for (int r = 0; r < 4; r++) send_row(v1[r], rnd_sample(), rnd_sample(), rnd_sample(), w);
        bus.in_valid = 1'b0;
        check("round_valid", bus.out_valid, 1);
        check("round_63", dout(0), 0);
        check("round_64", dout(1), 1);
        check("round_m64", dout(2), 0);
        check("round_m65", dout(3), -1);
        drain("round");

        // Saturation extremes and sign extension
        bus.out_ready = 1'b0;
        send_row(16777215, -16777216, 0, 0, w);
        send_row(-16777216, 16777215, 0, 0, w);
        send_row(0, 0, 0, 0, w);
        send_row(0, 0, 0, 0, w);
        bus.in_valid = 1'b0;
        check("sat_pos", dout(0), 32767);
        check("sat_neg", dout(1), -32768);
        check("sat_sext_bits", $unsigned(bus.d_out_2), 64'h1FF8000);
        drain("sat");

        // Back-to-back: 8 rows, 8 columns on consecutive cycles
        bus.out_ready = 1'b1;
        stalls = 0;
        c0 = n_cols;
        for (int i = 0; i < 8; i++) begin
            send_rand_row(w);
            stalls += w;
        end
        bus.in_valid = 1'b0;
        check("b2b_stalls", stalls, 0);
        check("b2b_cols_mid", n_cols - c0, 4);
        repeat (4) @(negedge clk);
        #1;
        check("b2b_cols_end", n_cols - c0, 8);
        drain("b2b");

        // Backpressure: both banks full, ninth row stalls until one bank drains
        bus.out_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send_rand_row(w);
            stalls += w;
        end
        check("bp_fill_stalls", stalls, 0);
        check("bp_in_ready_low", bus.in_ready, 0);
        drive_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d_in_ready", i), bus.in_ready, 0);
            for (int k = 0; k < 4; k++)
                check($sformatf("bp_hold%0d_e%0d", i, k), dout(k), exp_q[0].e[k]);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_row(int'($signed(bus.d_in_1)), int'($signed(bus.d_in_2)),
                 int'($signed(bus.d_in_3)), int'($signed(bus.d_in_4)), w);
        check("bp_row9_wait", w, 4);
        for (int i = 0; i < 3; i++) send_rand_row(w);
        drain("bp");

        // Reset with a full bank and a partial one
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_rand_row(w);
        bus.in_valid = 1'b0;
        check("mid_rst_pre_valid", bus.out_valid, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        blk_rows = 0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        for (int k = 0; k < 4; k++) check($sformatf("mid_rst_dout%0d", k), dout(k), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_rand_row(w);
        drain("post_rst");

        // Random traffic with random gaps and backpressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
            @(negedge clk);
            if (bus.in_valid && bus.in_ready)
                model_row(int'($signed(bus.d_in_1)), int'($signed(bus.d_in_2)),
                          int'($signed(bus.d_in_3)), int'($signed(bus.d_in_4)));
            @(posedge clk);
            #1;
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
